// File: rtl/pipe_stage_buf.sv
// rtl/pipe_stage_buf.sv - pipeline-stage holding register with valid/ready handshake and optional skid entry
module pipe_stage_buf #(
    parameter int DATA_W   = 32,
    parameter int CHANNELS = 4,
    parameter int SKID     = 1
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [CHANNELS*DATA_W-1:0] in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [CHANNELS*DATA_W-1:0] out_data,
    output logic [1:0]                 occupancy
);

    localparam int W = CHANNELS * DATA_W;

    // State encoding doubles as the occupancy count.
    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] FULL  = 2'd2;

    logic [1:0]   state_q, state_d;
    logic [W-1:0] main_q, main_d;
    logic [W-1:0] skid_q, skid_d;
    logic         in_fire, out_fire;

    assign out_valid = (state_q != EMPTY);
    assign occupancy = state_q;
    assign out_data  = main_q;
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        state_d = ONE;
                        main_d  = in_data;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_d = in_data;
                    end else if (in_fire && SKID != 0) begin
                        state_d = FULL;
                        skid_d  = in_data;
                    end else if (out_fire) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    // Skid entry is always the younger one, so it moves up on a pop.
                    if (out_fire) begin
                        state_d = ONE;
                        main_d  = skid_q;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    generate
        if (SKID != 0) begin : g_skid
            // Registered so backpressure never chains combinationally across stages.
            logic in_ready_q;
            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    in_ready_q <= 1'b1;
                end else begin
                    in_ready_q <= (state_d != FULL);
                end
            end
            assign in_ready = in_ready_q;
        end else begin : g_noskid
            assign in_ready = !out_valid | out_ready;
        end
    endgenerate

endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb/tb_pipe_stage_buf.sv - directed self-checking bench for pipe_stage_buf (skid and non-skid)
module tb_pipe_stage_buf;

    logic        clk = 1'b0;
    logic        resetn;

    logic        s_flush, s_in_valid, s_in_ready, s_out_valid, s_out_ready;
    logic [31:0] s_in_data, s_out_data;
    logic [1:0]  s_occ;

    logic        n_flush, n_in_valid, n_in_ready, n_out_valid, n_out_ready;
    logic [31:0] n_in_data, n_out_data;
    logic [1:0]  n_occ;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    pipe_stage_buf #(.DATA_W(8), .CHANNELS(4), .SKID(1)) u_skid (
        .clk(clk), .resetn(resetn), .flush(s_flush),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
        .occupancy(s_occ)
    );

    pipe_stage_buf #(.DATA_W(8), .CHANNELS(4), .SKID(0)) u_noskid (
        .clk(clk), .resetn(resetn), .flush(n_flush),
        .in_valid(n_in_valid), .in_ready(n_in_ready), .in_data(n_in_data),
        .out_valid(n_out_valid), .out_ready(n_out_ready), .out_data(n_out_data),
        .occupancy(n_occ)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        s_flush = 0; s_in_valid = 0; s_out_ready = 0; s_in_data = '0;
        n_flush = 0; n_in_valid = 0; n_out_ready = 0; n_in_data = '0;
        #1;
        tests++; if (s_out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b want 0", s_out_valid); end
        tests++; if (s_occ !== 2'd0) begin fails++; $display("FAIL reset_occ got %0d want 0", s_occ); end
        tests++; if (s_out_data !== 32'h0) begin fails++; $display("FAIL reset_out_data got %h want 0", s_out_data); end
        tests++; if (n_out_valid !== 1'b0) begin fails++; $display("FAIL reset_n_out_valid got %b want 0", n_out_valid); end
        tick(); tick();
        #2 resetn = 1'b1;
        tick();
        tests++; if (s_in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b want 1", s_in_ready); end
    endtask

    task automatic test_reset_mid();
        s_out_ready = 0; s_in_valid = 1; s_in_data = 32'h11;
        tick();
        s_in_data = 32'h22;
        tick();
        s_in_valid = 0;
        tests++; if (s_occ !== 2'd2) begin fails++; $display("FAIL midrst_fill_occ got %0d want 2", s_occ); end
        #2 resetn = 1'b0;
        #1;
        tests++; if (s_out_valid !== 1'b0) begin fails++; $display("FAIL midrst_out_valid got %b want 0", s_out_valid); end
        tests++; if (s_occ !== 2'd0) begin fails++; $display("FAIL midrst_occ got %0d want 0", s_occ); end
        tests++; if (s_out_data !== 32'h0) begin fails++; $display("FAIL midrst_out_data got %h want 0", s_out_data); end
        #1 resetn = 1'b1;
        tick();
        tests++; if (s_in_ready !== 1'b1) begin fails++; $display("FAIL midrst_in_ready got %b want 1", s_in_ready); end
        tests++; if (s_out_valid !== 1'b0) begin fails++; $display("FAIL midrst_post_valid got %b want 0", s_out_valid); end
    endtask

    task automatic test_streaming();
        s_out_ready = 1; s_in_valid = 1;
        n_out_ready = 1; n_in_valid = 1;
        for (int k = 1; k <= 8; k++) begin
            s_in_data = k; n_in_data = 32'h100 + k;
            tick();
            tests++; if (s_out_data !== 32'(k) || s_out_valid !== 1'b1) begin fails++; $display("FAIL stream_s_data[%0d] got %h/%b want %h/1", k, s_out_data, s_out_valid, k); end
            tests++; if (s_occ !== 2'd1 || s_in_ready !== 1'b1) begin fails++; $display("FAIL stream_s_occ[%0d] got occ=%0d rdy=%b want 1/1", k, s_occ, s_in_ready); end
            tests++; if (n_out_data !== 32'h100 + 32'(k) || n_occ !== 2'd1) begin fails++; $display("FAIL stream_n_data[%0d] got %h occ=%0d want %h/1", k, n_out_data, n_occ, 32'h100 + k); end
        end
        s_in_valid = 0; n_in_valid = 0;
        tick();
        tests++; if (s_occ !== 2'd0 || n_occ !== 2'd0) begin fails++; $display("FAIL stream_drain got %0d/%0d want 0/0", s_occ, n_occ); end
        s_out_ready = 0; n_out_ready = 0;
    endtask

    task automatic test_backpressure();
        s_out_ready = 0; s_in_valid = 1; s_in_data = 32'h11;
        tick();
        tests++; if (s_occ !== 2'd1 || s_in_ready !== 1'b1) begin fails++; $display("FAIL bp_first got occ=%0d rdy=%b want 1/1", s_occ, s_in_ready); end
        s_in_data = 32'h22;
        tick();
        s_in_valid = 0;
        tests++; if (s_occ !== 2'd2) begin fails++; $display("FAIL bp_occ2 got %0d want 2", s_occ); end
        tests++; if (s_in_ready !== 1'b0) begin fails++; $display("FAIL bp_in_ready got %b want 0", s_in_ready); end
        tests++; if (s_out_data !== 32'h11) begin fails++; $display("FAIL bp_head got %h want 11", s_out_data); end
        tick();
        tests++; if (s_out_data !== 32'h11 || s_occ !== 2'd2) begin fails++; $display("FAIL bp_hold got %h occ=%0d want 11/2", s_out_data, s_occ); end
        s_out_ready = 1;
        tick();
        tests++; if (s_out_data !== 32'h22 || s_occ !== 2'd1) begin fails++; $display("FAIL bp_pop1 got %h occ=%0d want 22/1", s_out_data, s_occ); end
        tests++; if (s_in_ready !== 1'b1) begin fails++; $display("FAIL bp_ready_after_pop got %b want 1", s_in_ready); end
        tick();
        tests++; if (s_out_valid !== 1'b0 || s_occ !== 2'd0) begin fails++; $display("FAIL bp_pop2 got valid=%b occ=%0d want 0/0", s_out_valid, s_occ); end
        s_out_ready = 0;
    endtask

    task automatic test_flush();
        s_out_ready = 0; s_in_valid = 1; s_in_data = 32'h44;
        tick();
        s_in_data = 32'h55;
        tick();
        s_flush = 1; s_in_data = 32'h33;
        tick();
        s_flush = 0; s_in_valid = 0;
        tests++; if (s_out_valid !== 1'b0 || s_occ !== 2'd0) begin fails++; $display("FAIL flush_full got valid=%b occ=%0d want 0/0", s_out_valid, s_occ); end
        tests++; if (s_in_ready !== 1'b1) begin fails++; $display("FAIL flush_in_ready got %b want 1", s_in_ready); end
        s_out_ready = 1;
        tick(); tick();
        tests++; if (s_out_valid !== 1'b0) begin fails++; $display("FAIL flush_no_33 got valid=%b data=%h want 0", s_out_valid, s_out_data); end
        // flush in ONE with an accepted entry on the same edge: that entry is dropped
        s_out_ready = 0; s_in_valid = 1; s_in_data = 32'h77;
        tick();
        s_flush = 1; s_in_data = 32'h66;
        tick();
        s_flush = 0; s_in_valid = 0;
        tests++; if (s_out_valid !== 1'b0 || s_occ !== 2'd0) begin fails++; $display("FAIL flush_one got valid=%b occ=%0d want 0/0", s_out_valid, s_occ); end
    endtask

    task automatic test_noskid_bp();
        n_out_ready = 0; n_in_valid = 1; n_in_data = 32'h77;
        tick();
        n_in_valid = 0;
        tests++; if (n_occ !== 2'd1 || n_out_data !== 32'h77) begin fails++; $display("FAIL ns_load got occ=%0d data=%h want 1/77", n_occ, n_out_data); end
        #1;
        tests++; if (n_in_ready !== 1'b0) begin fails++; $display("FAIL ns_ready_low got %b want 0", n_in_ready); end
        n_out_ready = 1; #1;
        tests++; if (n_in_ready !== 1'b1) begin fails++; $display("FAIL ns_ready_high got %b want 1", n_in_ready); end
        n_out_ready = 0; n_flush = 1; #1;
        tests++; if (n_in_ready !== 1'b0) begin fails++; $display("FAIL ns_flush_ready got %b want 0", n_in_ready); end
        n_flush = 0;
        tick();
        tests++; if (n_out_data !== 32'h77) begin fails++; $display("FAIL ns_hold got %h want 77", n_out_data); end
        n_out_ready = 1; n_in_valid = 1; n_in_data = 32'h88;
        tick();
        n_in_valid = 0;
        tests++; if (n_occ !== 2'd1 || n_out_data !== 32'h88) begin fails++; $display("FAIL ns_swap got occ=%0d data=%h want 1/88", n_occ, n_out_data); end
        tick();
        tests++; if (n_occ !== 2'd0 || n_out_valid !== 1'b0) begin fails++; $display("FAIL ns_drain got occ=%0d valid=%b want 0/0", n_occ, n_out_valid); end
        n_out_ready = 0;
    endtask

    task automatic test_lanes();
        s_out_ready = 0; s_in_valid = 1; s_in_data = 32'hDDCCBBAA;
        tick();
        s_in_valid = 0; s_in_data = 32'h0;
        tests++; if (s_out_data !== 32'hDDCCBBAA) begin fails++; $display("FAIL lane_bus got %h want ddccbbaa", s_out_data); end
        tests++; if (s_out_data[7:0] !== 8'hAA) begin fails++; $display("FAIL lane_ch0 got %h want aa", s_out_data[7:0]); end
        tests++; if (s_out_data[31:24] !== 8'hDD) begin fails++; $display("FAIL lane_ch3 got %h want dd", s_out_data[31:24]); end
        s_out_ready = 1;
        tick();
        s_out_ready = 0;
        tests++; if (s_out_valid !== 1'b0) begin fails++; $display("FAIL lane_drain got %b want 0", s_out_valid); end
    endtask

    initial begin
        test_reset();
        test_reset_mid();
        test_streaming();
        test_backpressure();
        test_flush();
        test_noskid_bp();
        test_lanes();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout after %0d tests", tests);
        $fatal(1);
    end

endmodule
